// File: rtl/wavetable_voice_reader.sv
// wavetable_voice_reader: on each audio tick, fetches one sample per active voice from a shared
// fixed-latency BRAM and presents their unsigned sum with a one-cycle valid strobe.
module wavetable_voice_reader #(
    parameter  int ADDR_WIDTH   = 8,
    parameter  int SAMPLE_WIDTH = 8,
    parameter  int MAX_VOICES   = 2,
    parameter  int BRAM_LATENCY = 2,
    localparam int NW           = $clog2(MAX_VOICES + 1),
    localparam int OW           = SAMPLE_WIDTH + $clog2(MAX_VOICES)
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   sample_tick_in,
    input  logic [MAX_VOICES-1:0][ADDR_WIDTH-1:0]  addr_in,
    input  logic [NW-1:0]                          num_voices_in,
    output logic [ADDR_WIDTH-1:0]                  bram_addr_out,
    input  logic [SAMPLE_WIDTH-1:0]                bram_data_in,
    output logic [OW-1:0]                          sample_out,
    output logic                                   sample_valid_out,
    output logic                                   busy_out,
    output logic [7:0]                             overrun_count_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [NW-1:0]           MAXV = NW'(MAX_VOICES);
    localparam logic [BRAM_LATENCY-1:0] REST = {BRAM_LATENCY{1'b1}} >> 1;

    state_t                                state_q, state_d;
    logic [MAX_VOICES-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NW-1:0]                         left_q, left_d, n;
    logic [BRAM_LATENCY-1:0]               tag_q, tag_d;
    logic [OW-1:0]                         acc_q, acc_d, sample_q, sample_d;
    logic [ADDR_WIDTH-1:0]                 bram_addr_q, bram_addr_d;
    logic [7:0]                            ovr_q, ovr_d;
    logic                                  accept, busy, emerge;

    assign busy   = state_q == ISSUE || state_q == DRAIN;
    assign accept = sample_tick_in && !busy;
    assign emerge = tag_q[BRAM_LATENCY-1];
    assign n      = num_voices_in > MAXV ? MAXV : num_voices_in;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        bram_addr_d = bram_addr_q;
        tag_d       = (tag_q << 1) | BRAM_LATENCY'(state_q == ISSUE);
        acc_d       = acc_q + (emerge ? OW'(bram_data_in) : '0);
        ovr_d       = (sample_tick_in && busy && ovr_q != 8'hff) ? ovr_q + 8'd1 : ovr_q;
        // addr_q is a shift queue: entry 0 is always the next address to present
        if (accept) begin
            acc_d   = '0;
            addr_d  = addr_in >> ADDR_WIDTH;
            left_d  = n;
            state_d = n == '0 ? DONE : ISSUE;
            bram_addr_d = n == '0 ? bram_addr_q : addr_in[0];
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (state_q == ISSUE) begin
            if (left_q == NW'(1)) begin
                state_d = DRAIN;
            end else begin
                bram_addr_d = addr_q[0];
                addr_d      = addr_q >> ADDR_WIDTH;
                left_d      = left_q - NW'(1);
            end
        end else if (state_q == DRAIN && emerge && (tag_q & REST) == '0) begin
            state_d = DONE;
        end
        sample_d = state_d == DONE ? acc_d : sample_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            bram_addr_q <= '0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            bram_addr_q <= bram_addr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bram_addr_out     = bram_addr_q;
    assign sample_out        = sample_q;
    assign sample_valid_out  = state_q == DONE;
    assign busy_out          = busy;
    assign overrun_count_out = ovr_q;
endmodule
